// File: rtl/rvfi_commit_tracker.sv
// Multi-lane RVFI commit bookkeeping: order assignment, halt-loop detection, no-commit watchdog.
// Optional lane-contiguity check enabled by defining RVFI_LANE_CHECK_EN.
module rvfi_commit_tracker #(
    parameter int NUM_CH         = 2,
    parameter int XLEN           = 32,
    parameter int ORDER_W        = 64,
    parameter int HALT_REPEAT    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*XLEN-1:0]     in_pc_rdata,
    input  logic [NUM_CH*XLEN-1:0]     in_pc_wdata,
    output logic [NUM_CH-1:0]          out_commit,
    output logic [NUM_CH*ORDER_W-1:0]  out_order,
    output logic                       halt,
    output logic                       timeout,
    output logic [ORDER_W-1:0]         total_commits,
    output logic                       lane_err
);

    localparam int LOOP_W = $clog2(HALT_REPEAT + NUM_CH + 1);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOOP_W-1:0] LOOP_TGT = LOOP_W'(HALT_REPEAT);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALTED    = 2'd1,
        ST_TIMED_OUT = 2'd2
    } state_e;

    state_e                      state_r, state_s;
    logic [LOOP_W-1:0]           loop_cnt_r, loop_cnt_s;
    logic [XLEN-1:0]             loop_pc_r, loop_pc_s;
    logic [IDLE_W-1:0]           idle_cnt_r, idle_cnt_s;
    logic [ORDER_W-1:0]          total_r, total_s;
    logic [NUM_CH-1:0]           commit_r, commit_s;
    logic [NUM_CH*ORDER_W-1:0]   order_r, order_s;
    logic                        halt_r, timeout_r, lane_err_r, lane_err_s;
    logic                        loop_hit_s;
    logic [XLEN-1:0]             pc_s;

`ifdef RVFI_LANE_CHECK_EN
    // A valid lane above an invalid one makes v & (v+1) non-zero.
    function automatic logic has_gap(input logic [NUM_CH-1:0] v);
        return (v & (v + NUM_CH'(1))) != '0;
    endfunction
`endif

    // Next-state, order assignment, loop tracking and watchdog.
    always_comb begin
        state_s    = state_r;
        loop_cnt_s = loop_cnt_r;
        loop_pc_s  = loop_pc_r;
        idle_cnt_s = idle_cnt_r;
        total_s    = total_r;
        commit_s   = '0;
        order_s    = '0;
        lane_err_s = lane_err_r;
        loop_hit_s = 1'b0;
        pc_s       = '0;
        if (state_r == ST_RUN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pc_s = in_pc_rdata[i*XLEN +: XLEN];
                if (in_valid[i]) begin
                    commit_s[i]                     = 1'b1;
                    order_s[i*ORDER_W +: ORDER_W]   = total_s;
                    total_s                         = total_s + ORDER_W'(1);
                    if (in_pc_wdata[i*XLEN +: XLEN] == pc_s) begin
                        if (pc_s == loop_pc_s) begin
                            loop_cnt_s = loop_cnt_s + LOOP_W'(1);
                        end else begin
                            loop_cnt_s = LOOP_W'(1);
                        end
                        loop_pc_s = pc_s;
                    end else begin
                        loop_cnt_s = '0;
                    end
                    if (loop_cnt_s >= LOOP_TGT) begin
                        loop_hit_s = 1'b1;
                    end else begin
                        loop_hit_s = loop_hit_s;
                    end
                end else begin
                    loop_cnt_s = loop_cnt_s;
                end
            end
            if (in_valid != '0) begin
                idle_cnt_s = '0;
            end else if (idle_cnt_r != IDLE_MAX) begin
                idle_cnt_s = idle_cnt_r + IDLE_W'(1);
            end else begin
                idle_cnt_s = idle_cnt_r;
            end
            // Halt takes priority; a timeout edge can only occur with no lane valid anyway.
            if (loop_hit_s) begin
                state_s = ST_HALTED;
            end else if ((in_valid == '0) && (idle_cnt_r == IDLE_MAX)) begin
                state_s = ST_TIMED_OUT;
            end else begin
                state_s = ST_RUN;
            end
`ifdef RVFI_LANE_CHECK_EN
            lane_err_s = lane_err_r | has_gap(in_valid);
`else
            lane_err_s = 1'b0;
`endif
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            loop_cnt_r <= '0;
            loop_pc_r  <= '0;
            idle_cnt_r <= '0;
            total_r    <= '0;
            commit_r   <= '0;
            order_r    <= '0;
            halt_r     <= 1'b0;
            timeout_r  <= 1'b0;
            lane_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            loop_cnt_r <= loop_cnt_s;
            loop_pc_r  <= loop_pc_s;
            idle_cnt_r <= idle_cnt_s;
            total_r    <= total_s;
            commit_r   <= commit_s;
            order_r    <= order_s;
            halt_r     <= (state_s == ST_HALTED);
            timeout_r  <= (state_s == ST_TIMED_OUT);
            lane_err_r <= lane_err_s;
        end
    end

    assign out_commit    = commit_r;
    assign out_order     = order_r;
    assign halt          = halt_r;
    assign timeout       = timeout_r;
    assign total_commits = total_r;
    assign lane_err      = lane_err_r;

endmodule
